// File: rtl/md5_block_engine_if.sv
// md5_block_engine_if: block-input and digest-output handshakes of md5_block_engine.
// slave is the engine side, master is the producer/consumer side.
interface md5_block_engine_if;
   logic         blk_valid_i;
   logic         blk_ready_o;
   logic [511:0] blk_i;
   logic         blk_first_i;
   logic         blk_last_i;
   logic [127:0] digest_o;
   logic         digest_valid_o;
   logic         digest_ready_i;
   logic         busy_o;
   logic [5:0]   step_o;

   modport slave (
      input  blk_valid_i, blk_i, blk_first_i, blk_last_i, digest_ready_i,
      output blk_ready_o, digest_o, digest_valid_o, busy_o, step_o
   );

   modport master (
      output blk_valid_i, blk_i, blk_first_i, blk_last_i, digest_ready_i,
      input  blk_ready_o, digest_o, digest_valid_o, busy_o, step_o
   );
endinterface

// File: rtl/md5_block_engine.sv
// md5_block_engine: MD5 compression of pre-padded 512-bit blocks, chaining across blocks.
// Optional macro MD5_IV_LOAD_EN adds port iv_i, used as start value of new messages.
module md5_block_engine #(
   parameter int           STEPS_PER_CYCLE = 1,
   parameter logic [127:0] IV              = 128'h67452301_EFCDAB89_98BADCFE_10325476
) (
   input  logic               clk_i,
   input  logic               rst_i,
`ifdef MD5_IV_LOAD_EN
   input  logic [127:0]       iv_i,
`endif
   md5_block_engine_if.slave  bus
);

   if (STEPS_PER_CYCLE != 1 && STEPS_PER_CYCLE != 2 && STEPS_PER_CYCLE != 4) begin : g_bad_steps
      $error("md5_block_engine: STEPS_PER_CYCLE must be 1, 2 or 4");
   end

   typedef enum logic [1:0] {IDLE, RUN, FINAL, HOLD} state_t;

   localparam logic [5:0] STEP_INC  = 6'(STEPS_PER_CYCLE);
   localparam logic [5:0] LAST_BASE = 6'(64 - STEPS_PER_CYCLE);

   localparam logic [31:0] K_TAB [64] = '{
      32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
      32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
      32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
      32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
      32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
      32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
      32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
      32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
      32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
      32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
      32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
      32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
      32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
      32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
      32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
      32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
   };

   // Rotation amounts indexed by {round, step mod 4}
   localparam logic [4:0] S_TAB [16] = '{
      5'd7, 5'd12, 5'd17, 5'd22,
      5'd5, 5'd9,  5'd14, 5'd20,
      5'd4, 5'd11, 5'd16, 5'd23,
      5'd6, 5'd10, 5'd15, 5'd21
   };

   function automatic logic [31:0] rotl32(input logic [31:0] x, input logic [4:0] s);
      logic [63:0] t;
      t = {x, x} << s;
      return t[63:32];
   endfunction

   function automatic logic [31:0] bswap32(input logic [31:0] x);
      return {x[7:0], x[15:8], x[23:16], x[31:24]};
   endfunction

   function automatic logic [127:0] md5_step(input logic [127:0] abcd, input logic [5:0] i,
                                             input logic [511:0] m);
      logic [31:0] a, b, c, d, f, t;
      logic [3:0]  g;
      a = abcd[127:96];
      b = abcd[95:64];
      c = abcd[63:32];
      d = abcd[31:0];
      case (i[5:4])
         2'd0:    begin f = (b & c) | (~b & d); g = i[3:0];                end
         2'd1:    begin f = (d & b) | (~d & c); g = i[3:0] * 4'd5 + 4'd1;  end
         2'd2:    begin f = b ^ c ^ d;          g = i[3:0] * 4'd3 + 4'd5;  end
         default: begin f = c ^ (b | ~d);       g = i[3:0] * 4'd7;         end
      endcase
      t = a + f + K_TAB[i] + m[{g, 5'd0} +: 32];
      return {d, b + rotl32(t, S_TAB[{i[5:4], i[1:0]}]), b, c};
   endfunction

   state_t         state_r, state_s;
   logic           ready_r, ready_s;
   logic           busy_r, busy_s;
   logic           valid_r, valid_s;
   logic [127:0]   digest_r, digest_s;
   logic [511:0]   blk_r;
   logic           last_r;
   logic [127:0]   start_r, work_r, chain_r;
   logic [5:0]     step_r;
   logic [127:0]   iv_src_s, start_sel_s, run_s, sum_s, digest_calc_s;

`ifdef MD5_IV_LOAD_EN
   assign iv_src_s = iv_i;
`else
   assign iv_src_s = IV;
`endif

   assign start_sel_s = bus.blk_first_i ? iv_src_s : chain_r;

   assign sum_s = {start_r[127:96] + work_r[127:96], start_r[95:64] + work_r[95:64],
                   start_r[63:32] + work_r[63:32],   start_r[31:0] + work_r[31:0]};

   assign digest_calc_s = {bswap32(sum_s[127:96]), bswap32(sum_s[95:64]),
                           bswap32(sum_s[63:32]),  bswap32(sum_s[31:0])};

   // STEPS_PER_CYCLE chained rounds from the current working value
   always_comb begin
      run_s = work_r;
      for (int j = 0; j < STEPS_PER_CYCLE; j++) begin
         run_s = md5_step(run_s, step_r + 6'(j), blk_r);
      end
   end

   // Next state and next registered handshake outputs
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (bus.blk_valid_i) state_s = RUN;
            else                 state_s = IDLE;
         end
         RUN: begin
            if (step_r == LAST_BASE) state_s = FINAL;
            else                     state_s = RUN;
         end
         FINAL: begin
            if (last_r) state_s = HOLD;
            else        state_s = IDLE;
         end
         HOLD: begin
            if (bus.digest_ready_i) state_s = IDLE;
            else                    state_s = HOLD;
         end
         default: state_s = IDLE;
      endcase
      ready_s = (state_s == IDLE);
      busy_s  = (state_s != IDLE);
      valid_s = (state_s == HOLD);
      if (state_r == FINAL && last_r) digest_s = digest_calc_s;
      else                            digest_s = digest_r;
   end

   // State register and registered outputs
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r  <= IDLE;
         ready_r  <= 1'b1;
         busy_r   <= 1'b0;
         valid_r  <= 1'b0;
         digest_r <= 128'd0;
      end else begin
         state_r  <= state_s;
         ready_r  <= ready_s;
         busy_r   <= busy_s;
         valid_r  <= valid_s;
         digest_r <= digest_s;
      end
   end

   // Block capture, round datapath and chaining
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         blk_r   <= 512'd0;
         last_r  <= 1'b0;
         start_r <= 128'd0;
         work_r  <= 128'd0;
         chain_r <= IV;
         step_r  <= 6'd0;
      end else begin
         case (state_r)
            IDLE: begin
               if (bus.blk_valid_i) begin
                  blk_r   <= bus.blk_i;
                  last_r  <= bus.blk_last_i;
                  start_r <= start_sel_s;
                  work_r  <= start_sel_s;
                  step_r  <= 6'd0;
               end
            end
            RUN: begin
               // Counter wraps to 0 after the final group of steps
               work_r <= run_s;
               step_r <= step_r + STEP_INC;
            end
            FINAL: begin
               if (last_r) chain_r <= iv_src_s;
               else        chain_r <= sum_s;
            end
            default: begin
               step_r <= step_r;
            end
         endcase
      end
   end

   assign bus.blk_ready_o    = ready_r;
   assign bus.busy_o         = busy_r;
   assign bus.digest_valid_o = valid_r;
   assign bus.digest_o       = digest_r;
   assign bus.step_o         = step_r;

endmodule
